// File: rtl/traffic_light_ctrl.sv
// Intersection phase controller: NS/EW light sequencing on a one-second tick,
// violation-triggered all-red extension, flashing-yellow night mode, violation tally.
module traffic_light_ctrl #(
  parameter logic [7:0] T_GREEN_NS = 8'd20,
  parameter logic [7:0] T_GREEN_EW = 8'd15,
  parameter logic [7:0] T_YELLOW   = 8'd3,
  parameter logic [7:0] T_ALL_RED  = 8'd2,
  parameter logic [7:0] T_PENALTY  = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_sec,
  input  logic       en,
  input  logic       night_mode,
  input  logic       viol_n,
  input  logic       viol_s,
  input  logic       viol_w,
  input  logic       viol_e,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [2:0] phase,
  output logic [7:0] countdown,
  output logic [7:0] viol_cnt
);

  localparam int unsigned CW = 8;
  localparam int unsigned NV = 4;
  localparam int unsigned RW = 3;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Zero-length durations would stall the countdown, so they run as one tick.
  localparam logic [CW-1:0] D_GNS = (T_GREEN_NS == 8'd0) ? 8'd1 : T_GREEN_NS;
  localparam logic [CW-1:0] D_GEW = (T_GREEN_EW == 8'd0) ? 8'd1 : T_GREEN_EW;
  localparam logic [CW-1:0] D_Y   = (T_YELLOW   == 8'd0) ? 8'd1 : T_YELLOW;
  localparam logic [CW-1:0] D_AR  = (T_ALL_RED  == 8'd0) ? 8'd1 : T_ALL_RED;
  localparam logic [CW-1:0] D_PEN = (T_PENALTY  == 8'd0) ? 8'd1 : T_PENALTY;
  localparam logic [CW:0]   PEN_SUM  = (CW+1)'(D_AR) + (CW+1)'(D_PEN);
  localparam logic [CW-1:0] D_AR_PEN = PEN_SUM[CW] ? {CW{1'b1}} : PEN_SUM[CW-1:0];

  typedef enum logic [2:0] {
    AR0   = 3'd0,
    NSG   = 3'd1,
    NSY   = 3'd2,
    AR1   = 3'd3,
    EWG   = 3'd4,
    EWY   = 3'd5,
    AR2   = 3'd6,
    NIGHT = 3'd7
  } state_t;

  state_t          state;
  state_t          succ;
  logic [CW-1:0]   succ_load;
  logic            pen_take;
  logic            pen_pend;
  logic            flash;
  logic [NV-1:0]   viol_now;
  logic [NV-1:0]   viol_q;
  logic [NV-1:0]   viol_rise;
  logic            rise_any;
  logic [RW-1:0]   rise_cnt;
  logic [CW:0]     cnt_sum;
  logic            qtick;
  logic            advance;

  // Violation edge detection and saturating tally arithmetic
  always_comb begin
    viol_now  = {viol_n, viol_s, viol_w, viol_e};
    viol_rise = viol_now & ~viol_q;
    rise_any  = |viol_rise;
    rise_cnt  = RW'(viol_rise[0]) + RW'(viol_rise[1]) + RW'(viol_rise[2]) + RW'(viol_rise[3]);
    cnt_sum   = (CW+1)'(viol_cnt) + (CW+1)'(rise_cnt);
  end

  // Successor state and the countdown it loads when the current phase expires
  always_comb begin
    succ      = state;
    succ_load = D_AR;
    pen_take  = 1'b0;
    unique case (state)
      AR0:     succ = night_mode ? NIGHT : NSG;
      NSG:     succ = NSY;
      NSY:     succ = AR1;
      AR1:     succ = night_mode ? NIGHT : EWG;
      EWG:     succ = EWY;
      EWY:     succ = AR2;
      AR2:     succ = night_mode ? NIGHT : NSG;
      NIGHT:   succ = AR0;
      default: succ = AR0;
    endcase
    unique case (succ)
      NSG:     succ_load = D_GNS;
      EWG:     succ_load = D_GEW;
      NSY,
      EWY:     succ_load = D_Y;
      AR1,
      AR2: begin
        pen_take  = pen_pend | rise_any;
        succ_load = pen_take ? D_AR_PEN : D_AR;
      end
      NIGHT:   succ_load = '0;
      default: succ_load = D_AR;
    endcase
  end

  assign qtick   = tick_sec & en;
  assign advance = qtick & ((state == NIGHT) ? ~night_mode : (countdown == 8'd1));

  // Phase, countdown, flash and violation bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= AR0;
      countdown <= D_AR;
      flash     <= 1'b1;
      viol_q    <= '0;
      viol_cnt  <= '0;
      pen_pend  <= 1'b0;
    end else begin
      viol_q   <= viol_now;
      viol_cnt <= cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];

      if (advance && pen_take)
        pen_pend <= 1'b0;
      else if (rise_any)
        pen_pend <= 1'b1;

      if (advance) begin
        state     <= succ;
        countdown <= succ_load;
        if (succ == NIGHT)
          flash <= 1'b1;
      end else if (qtick) begin
        if (state == NIGHT)
          flash <= ~flash;
        else
          countdown <= countdown - 8'd1;
      end
    end
  end

  // Light decode; only one direction can leave red outside NIGHT
  always_comb begin
    light_ns = LT_RED;
    light_ew = LT_RED;
    phase    = state;
    unique case (state)
      NSG:     light_ns = LT_GRN;
      NSY:     light_ns = LT_YEL;
      EWG:     light_ew = LT_GRN;
      EWY:     light_ew = LT_YEL;
      NIGHT: begin
        light_ns = {1'b0, flash, 1'b0};
        light_ew = {1'b0, flash, 1'b0};
      end
      default: begin
        light_ns = LT_RED;
        light_ew = LT_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short durations
// (G_NS=3, G_EW=2, Y=1, AR=1, P=3).
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] O = 3'b000;
  localparam int unsigned NVEC = 46;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_sec, en, night_mode;
  logic       viol_n, viol_s, viol_w, viol_e;
  logic [2:0] light_ns, light_ew, phase;
  logic [7:0] countdown, viol_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       tick;
    logic       en;
    logic       night;
    logic [3:0] viol;
    logic [2:0] ph;
    logic [7:0] cd;
    logic [2:0] lns;
    logic [2:0] lew;
    logic [7:0] vc;
  } vec_t;

  vec_t vt [NVEC];

  traffic_light_ctrl #(
    .T_GREEN_NS(8'd3),
    .T_GREEN_EW(8'd2),
    .T_YELLOW  (8'd1),
    .T_ALL_RED (8'd1),
    .T_PENALTY (8'd3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_sec  (tick_sec),
    .en        (en),
    .night_mode(night_mode),
    .viol_n    (viol_n),
    .viol_s    (viol_s),
    .viol_w    (viol_w),
    .viol_e    (viol_e),
    .light_ns  (light_ns),
    .light_ew  (light_ew),
    .phase     (phase),
    .countdown (countdown),
    .viol_cnt  (viol_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic t, input logic e, input logic n, input logic [3:0] v,
                              input logic [2:0] p, input logic [7:0] c,
                              input logic [2:0] a, input logic [2:0] b, input logic [7:0] k);
    vec_t r;
    r.tick = t; r.en = e; r.night = n; r.viol = v;
    r.ph = p; r.cd = c; r.lns = a; r.lew = b; r.vc = k;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic t);
    tick_sec = t;
    @(negedge clk);
    tick_sec = 1'b0;
  endtask

  initial begin
    // reset + full cycle
    vt[0]  = mk(0, 1, 0, 4'b0000, 3'd0, 8'd1, R, R, 8'd0);
    vt[1]  = mk(1, 1, 0, 4'b0000, 3'd1, 8'd3, G, R, 8'd0);
    vt[2]  = mk(1, 1, 0, 4'b0000, 3'd1, 8'd2, G, R, 8'd0);
    vt[3]  = mk(1, 1, 0, 4'b0000, 3'd1, 8'd1, G, R, 8'd0);
    vt[4]  = mk(1, 1, 0, 4'b0000, 3'd2, 8'd1, Y, R, 8'd0);
    vt[5]  = mk(1, 1, 0, 4'b0000, 3'd3, 8'd1, R, R, 8'd0);
    vt[6]  = mk(1, 1, 0, 4'b0000, 3'd4, 8'd2, R, G, 8'd0);
    vt[7]  = mk(1, 1, 0, 4'b0000, 3'd4, 8'd1, R, G, 8'd0);
    vt[8]  = mk(1, 1, 0, 4'b0000, 3'd5, 8'd1, R, Y, 8'd0);
    vt[9]  = mk(1, 1, 0, 4'b0000, 3'd6, 8'd1, R, R, 8'd0);
    vt[10] = mk(1, 1, 0, 4'b0000, 3'd1, 8'd3, G, R, 8'd0);
    // violation in NSG -> penalised AR1, plain AR2
    vt[11] = mk(0, 1, 0, 4'b1000, 3'd1, 8'd3, G, R, 8'd1);
    vt[12] = mk(1, 1, 0, 4'b1000, 3'd1, 8'd2, G, R, 8'd1);
    vt[13] = mk(1, 1, 0, 4'b1000, 3'd1, 8'd1, G, R, 8'd1);
    vt[14] = mk(1, 1, 0, 4'b1000, 3'd2, 8'd1, Y, R, 8'd1);
    vt[15] = mk(1, 1, 0, 4'b1000, 3'd3, 8'd4, R, R, 8'd1);
    vt[16] = mk(1, 1, 0, 4'b1000, 3'd3, 8'd3, R, R, 8'd1);
    vt[17] = mk(1, 1, 0, 4'b1000, 3'd3, 8'd2, R, R, 8'd1);
    vt[18] = mk(1, 1, 0, 4'b1000, 3'd3, 8'd1, R, R, 8'd1);
    vt[19] = mk(1, 1, 0, 4'b1000, 3'd4, 8'd2, R, G, 8'd1);
    vt[20] = mk(1, 1, 0, 4'b1000, 3'd4, 8'd1, R, G, 8'd1);
    vt[21] = mk(1, 1, 0, 4'b1000, 3'd5, 8'd1, R, Y, 8'd1);
    vt[22] = mk(1, 1, 0, 4'b1000, 3'd6, 8'd1, R, R, 8'd1);
    vt[23] = mk(1, 1, 0, 4'b1000, 3'd1, 8'd3, G, R, 8'd1);
    // edge in the AR1 entry cycle, then freeze with a viol_e edge
    vt[24] = mk(1, 1, 0, 4'b0000, 3'd1, 8'd2, G, R, 8'd1);
    vt[25] = mk(1, 1, 0, 4'b0000, 3'd1, 8'd1, G, R, 8'd1);
    vt[26] = mk(1, 1, 0, 4'b0000, 3'd2, 8'd1, Y, R, 8'd1);
    vt[27] = mk(1, 1, 0, 4'b1000, 3'd3, 8'd4, R, R, 8'd2);
    vt[28] = mk(1, 1, 0, 4'b1000, 3'd3, 8'd3, R, R, 8'd2);
    vt[29] = mk(1, 0, 0, 4'b1000, 3'd3, 8'd3, R, R, 8'd2);
    vt[30] = mk(1, 0, 0, 4'b1001, 3'd3, 8'd3, R, R, 8'd3);
    vt[31] = mk(1, 1, 0, 4'b1001, 3'd3, 8'd2, R, R, 8'd3);
    vt[32] = mk(1, 1, 0, 4'b1001, 3'd3, 8'd1, R, R, 8'd3);
    vt[33] = mk(1, 1, 0, 4'b1001, 3'd4, 8'd2, R, G, 8'd3);
    vt[34] = mk(1, 1, 0, 4'b1001, 3'd4, 8'd1, R, G, 8'd3);
    vt[35] = mk(1, 1, 0, 4'b1001, 3'd5, 8'd1, R, Y, 8'd3);
    vt[36] = mk(1, 1, 0, 4'b1001, 3'd6, 8'd4, R, R, 8'd3);
    // night request during AR2 takes effect only when AR2 expires
    vt[37] = mk(1, 1, 1, 4'b1001, 3'd6, 8'd3, R, R, 8'd3);
    vt[38] = mk(1, 1, 1, 4'b1001, 3'd6, 8'd2, R, R, 8'd3);
    vt[39] = mk(1, 1, 1, 4'b1001, 3'd6, 8'd1, R, R, 8'd3);
    vt[40] = mk(1, 1, 1, 4'b1001, 3'd7, 8'd0, Y, Y, 8'd3);
    vt[41] = mk(1, 1, 1, 4'b1001, 3'd7, 8'd0, O, O, 8'd3);
    vt[42] = mk(0, 1, 1, 4'b1001, 3'd7, 8'd0, O, O, 8'd3);
    vt[43] = mk(1, 1, 1, 4'b1001, 3'd7, 8'd0, Y, Y, 8'd3);
    vt[44] = mk(1, 1, 0, 4'b1001, 3'd0, 8'd1, R, R, 8'd3);
    vt[45] = mk(1, 1, 0, 4'b1001, 3'd1, 8'd3, G, R, 8'd3);

    rst = 1'b1; tick_sec = 1'b0; en = 1'b1; night_mode = 1'b0;
    {viol_n, viol_s, viol_w, viol_e} = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_cd", 32'(countdown), 32'd1);
    chk("rst_lns", 32'(light_ns), 32'(R));
    chk("rst_lew", 32'(light_ew), 32'(R));
    chk("rst_vc", 32'(viol_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      tick_sec   = vt[i].tick;
      en         = vt[i].en;
      night_mode = vt[i].night;
      {viol_n, viol_s, viol_w, viol_e} = vt[i].viol;
      @(negedge clk);
      chk($sformatf("v%0d_phase", i), 32'(phase), 32'(vt[i].ph));
      chk($sformatf("v%0d_cd", i), 32'(countdown), 32'(vt[i].cd));
      chk($sformatf("v%0d_lns", i), 32'(light_ns), 32'(vt[i].lns));
      chk($sformatf("v%0d_lew", i), 32'(light_ew), 32'(vt[i].lew));
      chk($sformatf("v%0d_vc", i), 32'(viol_cnt), 32'(vt[i].vc));
      if (phase != 3'd7)
        chk($sformatf("v%0d_safety", i), 32'((light_ns != R) && (light_ew != R)), 32'd0);
    end
    tick_sec = 1'b0;

    // night request mid-green: NSG and NSY run out, AR1 completes, then NIGHT
    night_mode = 1'b1;
    cyc(1); chk("ng_nsg2", 32'(phase), 32'd1);
    cyc(1); chk("ng_nsg1", 32'(phase), 32'd1);
    cyc(1); chk("ng_nsy", 32'(phase), 32'd2);
    cyc(1); chk("ng_ar1", 32'(phase), 32'd3);
    cyc(1); chk("ng_night", 32'(phase), 32'd7);
    chk("ng_lns", 32'(light_ns), 32'(Y));
    night_mode = 1'b0;
    cyc(1); chk("ng_exit_ph", 32'(phase), 32'd0);
    chk("ng_exit_cd", 32'(countdown), 32'd1);

    // freeze: ticks ignored with en low, viol_e edge still counted
    cyc(1); chk("fz_nsg", 32'(countdown), 32'd3);
    en = 1'b0;
    {viol_n, viol_s, viol_w, viol_e} = 4'b0000;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) viol_e = 1'b1;
      cyc(1);
    end
    chk("fz_cd", 32'(countdown), 32'd3);
    chk("fz_ph", 32'(phase), 32'd1);
    chk("fz_vc", 32'(viol_cnt), 32'd4);

    // asynchronous reset mid-phase loses the tally
    #2 rst = 1'b1;
    #1;
    chk("arst_ph", 32'(phase), 32'd0);
    chk("arst_cd", 32'(countdown), 32'd1);
    chk("arst_vc", 32'(viol_cnt), 32'd0);
    {viol_n, viol_s, viol_w, viol_e} = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // four simultaneous edges, then saturation
    {viol_n, viol_s, viol_w, viol_e} = 4'b1111;
    cyc(0); chk("sat_four", 32'(viol_cnt), 32'd4);
    {viol_n, viol_s, viol_w, viol_e} = 4'b0000;
    cyc(0);
    for (int i = 0; i < 250; i++) begin
      viol_n = 1'b1; cyc(0);
      viol_n = 1'b0; cyc(0);
    end
    chk("sat_254", 32'(viol_cnt), 32'd254);
    viol_n = 1'b1; viol_s = 1'b1;
    cyc(0); chk("sat_255", 32'(viol_cnt), 32'd255);
    viol_w = 1'b1;
    cyc(0); chk("sat_hold", 32'(viol_cnt), 32'd255);
    chk("sat_ph", 32'(phase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Phase controller that drives the `light_ns`/`light_ew` {R,Y,G} codes consumed by the violation detector and the display renderer. It sequences NS-green, NS-yellow, all-red, EW-green, EW-yellow and all-red on a one-second tick. It extends the next all-red clearance when any violation flag rises, and supports a flashing-yellow night mode. It also keeps a saturating violation tally for the on-screen counter.

## Interface
- `T_GREEN_NS`, 8'd20: NS green duration, in ticks.
- `T_GREEN_EW`, 8'd15: EW green duration, in ticks.
- `T_YELLOW`, 8'd3: yellow duration, in ticks, for both directions.
- `T_ALL_RED`, 8'd2: all-red clearance duration, in ticks.
- `T_PENALTY`, 8'd3: extra all-red ticks added after a violation.
- Any duration parameter equal to 0 is treated as 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_sec`  in  1  one-cycle pulse, once per second.
- `en`  in  1  run enable. Low freezes phase and countdown.
- `night_mode`  in  1  request for flashing-yellow mode (level).
- `viol_n`, `viol_s`, `viol_w`, `viol_e`  in  1 each  latched violation flags (level).
- `light_ns`  out  3  {R,Y,G} code for NS.
- `light_ew`  out  3  {R,Y,G} code for EW.
- `phase`  out  3  current state encoding.
- `countdown`  out  8  ticks remaining in the current phase. Reads 0 in NIGHT.
- `viol_cnt`  out  8  saturating count of violation rising edges.

## Operation
- States and `phase` encoding:
  - AR0=0: initial all-red.
  - NSG=1, NSY=2.
  - AR1=3.
  - EWG=4, EWY=5.
  - AR2=6.
  - NIGHT=7.
- Lights per state:
  - NSG: NS=001, EW=100.
  - NSY: NS=010, EW=100.
  - EWG: NS=100, EW=001.
  - EWY: NS=100, EW=010.
  - AR0/AR1/AR2: both 100.
  - NIGHT: both {0,flash,0}.
- Safety invariant: outside NIGHT, at most one direction is non-red.
- Phase sequence: AR0→NSG→NSY→AR1→EWG→EWY→AR2→NSG.
- On entering a state, `countdown` loads that state's duration.
- A qualified tick is a cycle with `tick_sec && en`.
- On each qualified tick:
  - If `countdown`==1, advance to the next state and load its duration.
  - Otherwise, decrement `countdown`.
- Result: every state lasts exactly its duration in qualified ticks.
- Violation edge detect:
  - `viol_*` are registered every clk, independent of `en`.
  - A rising edge is current=1 while previous=0.
  - `viol_cnt` adds the number of rising edges in that cycle (0–4) and saturates at 255.
  - Any edge sets `pen_pend`.
- Penalty:
  - On entry to AR1 or AR2, if `pen_pend` is set or an edge occurs in the entry cycle, load min(255, `T_ALL_RED`+`T_PENALTY`) and clear `pen_pend`.
  - Otherwise load `T_ALL_RED`.
  - AR0 never takes a penalty. `pen_pend` persists through AR0.
- Night entry:
  - At the transition out of AR0, AR1 or AR2, if `night_mode`=1, go to NIGHT instead of the green state.
  - On entry, `flash`=1.
- In NIGHT, `flash` toggles on each qualified tick.
- Night exit: on a qualified tick with `night_mode`=0, go to AR0 with `countdown`=`T_ALL_RED`.
- Night requests are never honoured mid-green or mid-yellow.
- `en`=0 behaviour:
  - `tick_sec` is ignored.
  - State, `countdown` and `flash` hold.
  - Violation counting and `pen_pend` still update.

## Timing
- Reset values (asynchronous):
  - State AR0, `countdown`=`T_ALL_RED`.
  - `light_ns`=`light_ew`=100, `phase`=0.
  - `viol_cnt`=0, `pen_pend`=0, `flash`=1.
  - Registered viol history = 0.
- State, `countdown`, `flash` and `viol_cnt` are registers.
- `light_*` and `phase` are combinational decodes of the state registers.
- Outputs change on the clk edge that samples the qualified tick. There is no further latency.
- `viol_cnt` updates on the clk edge following the cycle in which the rising edge is present at the input.
- `rst` asserted mid-phase returns to AR0 immediately. The tally is lost.
- A `tick_sec` held high for N cycles counts as N ticks; the source guarantees single-cycle pulses.

## Test plan
- Reset and AR0 exit: assert `rst`, then release it with `T_ALL_RED`=2 → lights 100/100, `countdown`=2, `viol_cnt`=0. After 2 ticks, `phase`=1 with NS=001.
- Full cycle: set G_NS=3, G_EW=2, Y=1, AR=1, `en`=1, and run 16 ticks → phase trace 0,1,1,1,2,3,4,4,5,6,1,… with `countdown` decrementing 3,2,1 in NSG. Both directions are never non-red together.
- Penalty: raise `viol_n` during NSG with AR=1, P=3 → `viol_cnt`=1. The next AR1 lasts 4 ticks. The following AR2 lasts 1 tick.
- Simultaneous edges and saturation: raise all four `viol_*` in one cycle → `viol_cnt` +4. Preload to 254 and raise two → `viol_cnt`=255, and it stays 255 on a further edge.
- Night mode: assert `night_mode` during EWG → EWG and EWY complete, AR2 completes, then `phase`=7 with lights 010/010. Yellow toggles to 000 on the next tick. Deassert `night_mode` → next tick gives AR0.
- Freeze: drop `en` in NSG with `countdown`=5 and apply 10 `tick_sec` pulses → `countdown` stays 5. A `viol_e` edge meanwhile increments `viol_cnt`.
